alu_exec: RTL and testbench
===========================

# alu_exec

Integer execute stage directly downstream of the reservation station. Accepts one ready operation per cycle (operands, opcode, ROB index), computes the result, and broadcasts it on the ALU write-back bus (`alu_wb_*`) consumed by the reservation station, load/store buffer and ROB. A small in-order result queue decouples compute latency from the bus. An optional two-stage RV32M multiplier shares the queue.

## Interface
- `RQ_DEPTH`, default 4: result queue entries; power of two, minimum 2.
- Widths come from config.v: `RS_TYPE_BIT` (opcode; at least 5 bits used) and `ROB_SIZE_BIT`.
- `clk_in` input 1: system clock; the only clock.
- `rst_in` input 1: reset, synchronous, active-high.
- `rdy_in` input 1: global enable; the block holds all state when low.
- `rob_clear` input 1: misprediction flush.
- `alu_valid` input 1: issue strobe from the RS.
- `alu_r1`, `alu_r2` input 32: operands.
- `alu_op` input `RS_TYPE_BIT`: opcode.
- `alu_rob_idx` input `ROB_SIZE_BIT`: destination ROB entry.
- `alu_ready` output 1: may issue this cycle; the RS gates `alu_valid` with it.
- `alu_wb_valid` output 1: result broadcast valid.
- `alu_wb_idx` output `ROB_SIZE_BIT`: ROB index of the result.
- `alu_wb_value` output 32: result value.

## Operation
- Opcodes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - SLL=5, SRL=6, SRA=7: shift amount is `r2[4:0]`.
  - SLT=8, SLTU=9.
  - EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15: branch compares; result is 32'd1 or 32'd0.
  - MUL=16, MULH=17, MULHSU=18, MULHU=19: only with `ALU_MUL_EN`.
  - Any other opcode: result 0, still written back.
- Arithmetic wraps modulo 2^32. Signed ops treat the operands as two's complement.
- Issue is accepted when `alu_valid && alu_ready && rdy_in && !rob_clear && !rst_in`.
- Plain op: result computed combinationally and enqueued at the end of the issue cycle.
- Multiply op: operands, opcode and index latch into the M1 register (`m1_valid`) at issue. The product is enqueued at the end of the following cycle.
- Simultaneous enqueue: the M1 product is written before the plain result, preserving issue order. The queue accepts at most 2 writes per cycle.
- Queue head drives the write-back outputs:
  - `alu_wb_valid = (count != 0)`.
  - `alu_wb_idx` and `alu_wb_value` are the head entry, forced to 0 when the queue is empty.
  - The head is dequeued every `rdy_in` cycle in which `count != 0`. The bus has no back-pressure.
- `alu_ready = (count + m1_valid) < RQ_DEPTH`, computed from registered state only. This guarantees no overflow for any issue sequence.
- Pointers wrap modulo `RQ_DEPTH`. `count` is `log2(RQ_DEPTH)+1` bits wide.

## Timing
- Plain-op latency: issue in cycle N, `alu_wb_valid` in cycle N+1 if the queue was empty, later if entries are waiting.
- Multiply latency: write-back in N+2 at the earliest.
- Throughput: one write-back per cycle.
- Reset (`rst_in` high at a clock edge): queue empty, `m1_valid`=0, pointers 0. Resulting outputs: `alu_ready`=1, `alu_wb_valid`=0, `alu_wb_idx`=0, `alu_wb_value`=0. Reset takes priority over `rdy_in` and `rob_clear`.
- `rob_clear` high at an edge (with `rdy_in`):
  - Queue and M1 are emptied.
  - Any same-cycle issue is dropped.
  - `alu_wb_valid`=0 from the next cycle.
  - `rob_clear` is honoured even when `rdy_in` is low.
- `rdy_in` low: no enqueue, dequeue or M1 advance. Outputs hold their values.
- Full queue: `alu_ready`=0. An `alu_valid` that arrives anyway is ignored, and the queue is not corrupted.
- Empty queue with issue in the same cycle: no bypass. The result appears the next cycle.

## Configuration
- `ALU_MUL_EN` defined:
  - M1 stage is built.
  - Opcodes 16–19 execute: low 32 bits of the signed×signed product; high 32 bits of signed×signed, signed×unsigned and unsigned×unsigned products respectively.
  - Dual-enqueue path is present.
- `ALU_MUL_EN` undefined:
  - No M1 stage; `m1_valid` is constant 0.
  - Opcodes 16–19 return 0 with latency 1.
  - Single enqueue port.

## Test plan
- Reset, then issue ADD r1=5 r2=7 idx=3 → next cycle `alu_wb_valid`=1, idx=3, value=12; the cycle after, `alu_wb_valid`=0.
- Back-to-back issues: SUB 0−1, SRA 0x80000000>>4, SLTU 1<2, GEU 3≥3 → consecutive write-backs 0xFFFFFFFF, 0xF8000000, 1, 1, in order.
- `ALU_MUL_EN` set, MUL 0xFFFFFFFF×2 idx=1, then ADD 1+1 idx=2 in the next cycle → write-backs idx=1 value 0xFFFFFFFE, then idx=2 value 2, on consecutive cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Hold `rdy_in` low with 2 results queued for 5 cycles → outputs frozen on the first result. After release, both results appear in order, with no loss or duplication.
- Fill the queue with `alu_valid` held high → `alu_ready` drops before overflow. Then pulse `rob_clear` → next cycle `alu_wb_valid`=0 and `alu_ready`=1, and the same-cycle issue is never written back.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: integer execute stage; results pass through an in-order queue onto the ALU write-back bus.
// Optional two-stage RV32M multiplier built when the macro ALU_MUL_EN is defined.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module alu_exec #(
    parameter int RQ_DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,
    input  logic                     alu_valid,
    input  logic [31:0]              alu_r1,
    input  logic [31:0]              alu_r2,
    input  logic [`RS_TYPE_BIT-1:0]  alu_op,
    input  logic [`ROB_SIZE_BIT-1:0] alu_rob_idx,
    output logic                     alu_ready,
    output logic                     alu_wb_valid,
    output logic [`ROB_SIZE_BIT-1:0] alu_wb_idx,
    output logic [31:0]              alu_wb_value
);

    localparam int OPW  = `RS_TYPE_BIT;
    localparam int IDXW = `ROB_SIZE_BIT;
    localparam int PW   = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW   = PW + 1;

    localparam logic [OPW-1:0] OP_ADD    = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
    localparam logic [OPW-1:0] OP_AND    = OPW'(2);
    localparam logic [OPW-1:0] OP_OR     = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR    = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL    = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL    = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA    = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT    = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU   = OPW'(9);
    localparam logic [OPW-1:0] OP_EQ     = OPW'(10);
    localparam logic [OPW-1:0] OP_NE     = OPW'(11);
    localparam logic [OPW-1:0] OP_LT     = OPW'(12);
    localparam logic [OPW-1:0] OP_GE     = OPW'(13);
    localparam logic [OPW-1:0] OP_LTU    = OPW'(14);
    localparam logic [OPW-1:0] OP_GEU    = OPW'(15);
`ifdef ALU_MUL_EN
    localparam logic [OPW-1:0] OP_MUL    = OPW'(16);
    localparam logic [OPW-1:0] OP_MULH   = OPW'(17);
    localparam logic [OPW-1:0] OP_MULHSU = OPW'(18);
    localparam logic [OPW-1:0] OP_MULHU  = OPW'(19);
`endif

    // Single-cycle integer ops; unknown opcodes (and 16-19 without the multiplier) yield 0.
    function automatic logic [31:0] alu_calc(input logic [OPW-1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        res;
        sa  = a;
        sb  = b;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << b[4:0];
            OP_SRL:  res = a >> b[4:0];
            OP_SRA:  res = sa >>> b[4:0];
            OP_SLT:  res = {31'b0, sa < sb};
            OP_SLTU: res = {31'b0, a < b};
            OP_EQ:   res = {31'b0, a == b};
            OP_NE:   res = {31'b0, a != b};
            OP_LT:   res = {31'b0, sa < sb};
            OP_GE:   res = {31'b0, sa >= sb};
            OP_LTU:  res = {31'b0, a < b};
            OP_GEU:  res = {31'b0, a >= b};
            default: res = '0;
        endcase
        return res;
    endfunction

`ifdef ALU_MUL_EN
    // One 33x33 signed multiply covers all four variants by choosing how each operand is extended.
    function automatic logic [31:0] mul_calc(input logic [OPW-1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] prod;
        ea   = {(op != OP_MULHU) & a[31], a};
        eb   = {((op == OP_MUL) || (op == OP_MULH)) & b[31], b};
        prod = ea * eb;
        return (op == OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction
`endif

    logic [IDXW-1:0] idx_q [RQ_DEPTH];
    logic [31:0]     val_q [RQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic        accept;
    logic        is_mul;
    logic        plain_wr;
    logic        m1_wr;
    logic        m1_valid;
    logic        deq;
    logic [1:0]  n_wr;
    logic [31:0] res_p0;
    logic [31:0] prod_p1;
    logic [IDXW-1:0] m1_idx_p1;

    // Stage p0: issue decode and single-cycle compute
    assign accept   = alu_valid && alu_ready && rdy_in && !rob_clear && !rst_in;
    assign res_p0   = alu_calc(alu_op, alu_r1, alu_r2);
    assign plain_wr = accept && !is_mul;
    assign deq      = rdy_in && (count != '0);
    assign n_wr     = {1'b0, m1_wr} + {1'b0, plain_wr};

`ifdef ALU_MUL_EN
    logic [OPW-1:0] m1_op_p1;
    logic [31:0]    m1_a_p1;
    logic [31:0]    m1_b_p1;

    assign is_mul = (alu_op == OP_MUL) || (alu_op == OP_MULH) ||
                    (alu_op == OP_MULHSU) || (alu_op == OP_MULHU);

    always_ff @(posedge clk_in) begin
        if (rst_in || rob_clear) begin
            m1_valid <= 1'b0;
        end else if (rdy_in) begin
            m1_valid <= accept && is_mul;
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept && is_mul) begin
            m1_op_p1  <= alu_op;
            m1_a_p1   <= alu_r1;
            m1_b_p1   <= alu_r2;
            m1_idx_p1 <= alu_rob_idx;
        end
    end

    // Stage p1: multiplier product, enqueued ahead of any same-cycle plain result
    assign prod_p1 = mul_calc(m1_op_p1, m1_a_p1, m1_b_p1);
    assign m1_wr   = m1_valid && rdy_in && !rob_clear && !rst_in;
`else
    assign is_mul    = 1'b0;
    assign m1_valid  = 1'b0;
    assign m1_wr     = 1'b0;
    assign prod_p1   = '0;
    assign m1_idx_p1 = '0;
`endif

    // Queue control; an in-flight multiply reserves its slot so the queue never overflows
    assign alu_ready = ({1'b0, count} + (CW+1)'(m1_valid)) < (CW+1)'(RQ_DEPTH);

    always_ff @(posedge clk_in) begin
        if (rst_in || rob_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            wr_ptr <= wr_ptr + PW'(n_wr);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + CW'(n_wr) - CW'(deq);
        end
    end

    always_ff @(posedge clk_in) begin
        if (m1_wr) begin
            idx_q[wr_ptr] <= m1_idx_p1;
            val_q[wr_ptr] <= prod_p1;
        end
        if (plain_wr) begin
            idx_q[wr_ptr + PW'(m1_wr)] <= alu_rob_idx;
            val_q[wr_ptr + PW'(m1_wr)] <= res_p0;
        end
    end

    // Write-back bus: queue head, zeroed while empty
    assign alu_wb_valid = (count != '0);
    assign alu_wb_idx   = alu_wb_valid ? idx_q[rd_ptr] : '0;
    assign alu_wb_value = alu_wb_valid ? val_q[rd_ptr] : '0;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; multiplier checks follow whether ALU_MUL_EN is defined.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module tb_alu_exec;

    logic                     clk_in = 1'b0;
    logic                     rst_in = 1'b1;
    logic                     rdy_in = 1'b1;
    logic                     rob_clear = 1'b0;
    logic                     alu_valid = 1'b0;
    logic [31:0]              alu_r1 = '0;
    logic [31:0]              alu_r2 = '0;
    logic [`RS_TYPE_BIT-1:0]  alu_op = '0;
    logic [`ROB_SIZE_BIT-1:0] alu_rob_idx = '0;
    logic                     alu_ready;
    logic                     alu_wb_valid;
    logic [`ROB_SIZE_BIT-1:0] alu_wb_idx;
    logic [31:0]              alu_wb_value;

    int total = 0;
    int bad   = 0;

    alu_exec #(.RQ_DEPTH(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear    (rob_clear),
        .alu_valid    (alu_valid),
        .alu_r1       (alu_r1),
        .alu_r2       (alu_r2),
        .alu_op       (alu_op),
        .alu_rob_idx  (alu_rob_idx),
        .alu_ready    (alu_ready),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_idx   (alu_wb_idx),
        .alu_wb_value (alu_wb_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int op, input logic [31:0] a, input logic [31:0] b, input int idx);
        alu_op      = `RS_TYPE_BIT'(op);
        alu_r1      = a;
        alu_r2      = b;
        alu_rob_idx = `ROB_SIZE_BIT'(idx);
        alu_valid   = 1'b1;
    endtask

    task automatic chk_wb(input string tag, input int idx, input logic [31:0] val);
        chk({tag, "_vld"}, 32'(alu_wb_valid), 32'd1);
        chk({tag, "_idx"}, 32'(alu_wb_idx), 32'(idx));
        chk({tag, "_val"}, alu_wb_value, val);
    endtask

    // Issue one plain op (valid left high) and check its write-back on the next cycle.
    task automatic step_op(input string tag, input int op, input logic [31:0] a,
                           input logic [31:0] b, input int idx, input logic [31:0] exp);
        set_op(op, a, b, idx);
        tick();
        chk_wb(tag, idx, exp);
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_one(input string tag, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        set_op(op, a, b, 7);
        tick();
        alu_valid = 1'b0;
        chk({tag, "_m1"}, 32'(alu_wb_valid), 32'd0);
        tick();
        chk_wb(tag, 7, exp);
        tick();
    endtask
`endif

    initial begin
        // Reset
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_ready", 32'(alu_ready), 32'd1);
        chk("rst_vld",   32'(alu_wb_valid), 32'd0);
        chk("rst_idx",   32'(alu_wb_idx), 32'd0);
        chk("rst_val",   alu_wb_value, 32'd0);

        // Single ADD then idle
        step_op("add", 0, 32'd5, 32'd7, 3, 32'd12);
        alu_valid = 1'b0;
        tick();
        chk("add_drain", 32'(alu_wb_valid), 32'd0);

        // Back-to-back plain ops
        step_op("sub",   1, 32'd0, 32'd1, 1, 32'hFFFF_FFFF);
        step_op("sra",   7, 32'h8000_0000, 32'd4, 2, 32'hF800_0000);
        step_op("sltu",  9, 32'd1, 32'd2, 3, 32'd1);
        step_op("geu",  15, 32'd3, 32'd3, 4, 32'd1);
        step_op("xor",   4, 32'hFF00_FF00, 32'h0F0F_0F0F, 5, 32'hF00F_F00F);
        step_op("sll",   5, 32'd1, 32'h0000_003F, 6, 32'h8000_0000);
        step_op("srl",   6, 32'h8000_0000, 32'd31, 7, 32'd1);
        step_op("slt",   8, 32'hFFFF_FFFF, 32'd1, 8, 32'd1);
        step_op("lt",   12, 32'd1, 32'hFFFF_FFFF, 9, 32'd0);
        step_op("ltu",  14, 32'd1, 32'hFFFF_FFFF, 10, 32'd1);
        step_op("ne",   11, 32'd5, 32'd5, 11, 32'd0);
        step_op("eq",   10, 32'd5, 32'd5, 12, 32'd1);
        step_op("ge",   13, 32'hFFFF_FFFE, 32'd1, 13, 32'd0);
        step_op("and",   2, 32'hF0F0_1234, 32'h0FF0_FFFF, 14, 32'h00F0_1234);
        step_op("or",    3, 32'hF000_0000, 32'h0000_000F, 15, 32'hF000_000F);
        step_op("addwr", 0, 32'hFFFF_FFFF, 32'd2, 0, 32'd1);
        step_op("badop", 25, 32'd9, 32'd9, 1, 32'd0);
        alu_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(alu_wb_valid), 32'd0);

`ifdef ALU_MUL_EN
        // MUL followed by ADD: product first, then the add
        set_op(16, 32'hFFFF_FFFF, 32'd2, 1);
        tick();
        chk("mul_m1", 32'(alu_wb_valid), 32'd0);
        set_op(0, 32'd1, 32'd1, 2);
        tick();
        alu_valid = 1'b0;
        chk_wb("mul_first", 1, 32'hFFFF_FFFE);
        chk("mul_full_ready", 32'(alu_ready), 32'd0);
        tick();
        chk_wb("add_second", 2, 32'd2);
        tick();
        chk("mul_drain", 32'(alu_wb_valid), 32'd0);

        mul_one("mulhu",  19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        mul_one("mulh",   17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        mul_one("mulhsu", 18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

        // Two results queued, rdy_in low for 5 cycles
        set_op(16, 32'd3, 32'd4, 10);
        tick();
        set_op(0, 32'd5, 32'd6, 11);
        tick();
        alu_valid = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_wb("hold2", 10, 32'd12);
        end
        rdy_in = 1'b1;
        tick();
        chk_wb("hold2_second", 11, 32'd11);
        tick();
        chk("hold2_drain", 32'(alu_wb_valid), 32'd0);

        // Fill, ignored issue while full, then flush with a same-cycle issue
        set_op(16, 32'd1, 32'd1, 12);
        tick();
        set_op(0, 32'd0, 32'd0, 13);
        tick();
        chk("fill_ready", 32'(alu_ready), 32'd0);
        set_op(0, 32'd4, 32'd4, 14);
        tick();
        chk_wb("fill_head", 13, 32'd0);
        chk("fill_ready_back", 32'(alu_ready), 32'd1);
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        alu_valid = 1'b0;
        chk("mclr_vld", 32'(alu_wb_valid), 32'd0);
        chk("mclr_ready", 32'(alu_ready), 32'd1);
        tick();
        chk("mclr_dropped", 32'(alu_wb_valid), 32'd0);
`else
        // Without the multiplier, opcode 16 returns 0 with single-cycle latency
        step_op("mul_off", 16, 32'hFFFF_FFFF, 32'd2, 1, 32'd0);
        alu_valid = 1'b0;
        tick();
        chk("mul_off_drain", 32'(alu_wb_valid), 32'd0);
`endif

        // rdy_in low: outputs frozen, issue ignored, no duplicate afterwards
        step_op("hold1", 0, 32'd10, 32'd20, 5, 32'd30);
        set_op(0, 32'd1, 32'd1, 6);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_wb("hold1_frz", 5, 32'd30);
        end
        rdy_in = 1'b1;
        alu_valid = 1'b0;
        tick();
        chk("hold1_drain", 32'(alu_wb_valid), 32'd0);

        // Streaming issue keeps alu_ready high; rob_clear drops queue and same-cycle issue
        step_op("strm1", 0, 32'd1, 32'd0, 1, 32'd1);
        chk("strm1_ready", 32'(alu_ready), 32'd1);
        step_op("strm2", 0, 32'd2, 32'd0, 2, 32'd2);
        chk("strm2_ready", 32'(alu_ready), 32'd1);
        set_op(0, 32'd9, 32'd9, 9);
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        alu_valid = 1'b0;
        chk("clr_vld",   32'(alu_wb_valid), 32'd0);
        chk("clr_ready", 32'(alu_ready), 32'd1);
        chk("clr_val",   alu_wb_value, 32'd0);
        tick();
        chk("clr_dropped", 32'(alu_wb_valid), 32'd0);

        // rob_clear honoured while rdy_in is low
        step_op("clrlow", 0, 32'd3, 32'd3, 4, 32'd6);
        alu_valid = 1'b0;
        rdy_in = 1'b0;
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        chk("clrlow_vld", 32'(alu_wb_valid), 32'd0);
        rdy_in = 1'b1;
        tick();
        chk("clrlow_after", 32'(alu_wb_valid), 32'd0);

        // Reset beats a same-cycle issue
        set_op(0, 32'd8, 32'd8, 3);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        alu_valid = 1'b0;
        chk("rstpri_vld", 32'(alu_wb_valid), 32'd0);
        chk("rstpri_idx", 32'(alu_wb_idx), 32'd0);
        tick();
        chk("rstpri_after", 32'(alu_wb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
